// File: rtl/spu_pkg.sv
// ---------------------------------------------------------------------------
// spu_pkg
// Shared SPU definitions: default framebuffer geometry, draw-engine indices,
// arbiter state encoding and the round-robin successor helper.
// ---------------------------------------------------------------------------
package spu_pkg;

    // 320x240 = 76800 pixels -> 17 address bits, 8-bit palette index per pixel
    localparam int SPU_ADDR_W = 17;
    localparam int SPU_DATA_W = 8;

    // Draw-engine indices on the framebuffer arbiter
    localparam logic [1:0] REQ_MAP    = 2'd0;
    localparam logic [1:0] REQ_SPRITE = 2'd1;
    localparam logic [1:0] REQ_SCORE  = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Next engine index in the 0 -> 1 -> 2 -> 0 ring. An out-of-ring value
    // (OWNER_NONE) maps to engine 0 so the ring always starts somewhere sane.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= REQ_SCORE) ? REQ_MAP : idx + 2'd1;
    endfunction

endpackage

// File: rtl/spu_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// spu_fb_arbiter_if
// Bundle between the three draw engines, the framebuffer write port and the
// framebuffer arbiter.
//   req/req_addr/req_data : engine write requests (engine i at slice i)
//   gnt                   : per-engine one-cycle accept pulse
//   fb_we/fb_addr/fb_wdata: framebuffer write port, fb_ready = backpressure
//   busy/owner            : debug / frame-swap status (owner 3 = none)
// Modports: master = arbiter side, slave = engines + framebuffer side.
// ---------------------------------------------------------------------------
interface spu_fb_arbiter_if
    import spu_pkg::*;
#(
    parameter int ADDR_W = SPU_ADDR_W,
    parameter int DATA_W = SPU_DATA_W
);

    logic [2:0]          req;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          gnt;
    logic                fb_we;
    logic [ADDR_W-1:0]   fb_addr;
    logic [DATA_W-1:0]   fb_wdata;
    logic                fb_ready;
    logic                busy;
    logic [1:0]          owner;

    modport master (
        input  req, req_addr, req_data, fb_ready,
        output gnt, fb_we, fb_addr, fb_wdata, busy, owner
    );

    modport slave (
        output req, req_addr, req_data, fb_ready,
        input  gnt, fb_we, fb_addr, fb_wdata, busy, owner
    );

endinterface

// File: rtl/spu_rr_pick.sv
// ---------------------------------------------------------------------------
// spu_rr_pick
// Combinational 3-way round-robin picker. Searches last+1, last+2, last+3
// (mod 3) and returns the first requesting engine.
//   req   [2:0] : request bits, bit i = engine i
//   last  [1:0] : most recently released owner
//   valid       : at least one request present
//   pick  [1:0] : winning engine, OWNER_NONE when valid = 0
// ---------------------------------------------------------------------------
module spu_rr_pick
    import spu_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] pick
);

    logic [1:0] cand [3];
    logic [3:0] req_ext;

    // Pad so a 2-bit index can never fall off the end of the vector
    assign req_ext = {1'b0, req};

    // Priority order for this cycle: the three ring positions after last
    assign cand[0] = rr_next(last);
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_cand
            assign cand[gi] = rr_next(cand[gi-1]);
        end
    endgenerate

    always_comb begin
        valid = |req;
        pick  = OWNER_NONE;
        if (req_ext[cand[0]]) begin
            pick = cand[0];
        end else if (req_ext[cand[1]]) begin
            pick = cand[1];
        end else if (req_ext[cand[2]]) begin
            pick = cand[2];
        end
    end

endmodule

// File: rtl/spu_fb_arbiter.sv
// ---------------------------------------------------------------------------
// spu_fb_arbiter
// Shares the framebuffer write port among the map (0), sprite (1) and score (2)
// draw engines. Ownership is granted round-robin after one arbitration
// (IDLE) cycle and held until the owner drops req or MAX_BURST writes have
// been accepted. fb_ready backpressure stalls the owner without timeout.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spu_fb_arbiter_if.master (engine requests, grants,
//              framebuffer write port, busy/owner status)
// ---------------------------------------------------------------------------
module spu_fb_arbiter
    import spu_pkg::*;
#(
    parameter int ADDR_W    = SPU_ADDR_W,
    parameter int DATA_W    = SPU_DATA_W,
    parameter int MAX_BURST = 16            // 1..256
)(
    input  logic                   clk,
    input  logic                   rst,
    spu_fb_arbiter_if.master       bus
);

    // bcnt only ever holds 0..MAX_BURST-1, so 8 bits cover 256; the
    // increment is done at 9 bits so a limit of 256 compares correctly.
    localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

    arb_state_t  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q,  last_d;
    logic [7:0]  bcnt_q,  bcnt_d;

    logic              own;
    logic [3:0]        req_ext;
    logic [ADDR_W-1:0] addr_arr [4];
    logic [DATA_W-1:0] data_arr [4];
    logic              owner_req;
    logic              accept;
    logic [8:0]        bcnt_inc;
    logic              burst_done;
    logic              pick_valid;
    logic [1:0]        pick;

    // ------------------------------------------------------------------
    // Per-engine request slices. Slot 3 (OWNER_NONE) reads as zero.
    // ------------------------------------------------------------------
    assign req_ext = {1'b0, bus.req};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slice
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign addr_arr[3] = '0;
    assign data_arr[3] = '0;

    // ------------------------------------------------------------------
    // Round-robin selection, consulted only while IDLE
    // ------------------------------------------------------------------
    spu_rr_pick u_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .pick  (pick)
    );

    // ------------------------------------------------------------------
    // Write port: combinational from the owner's request. Everything is
    // qualified by own, so reset forces the port quiet immediately.
    // ------------------------------------------------------------------
    assign own        = (state_q == ARB_OWN);
    assign owner_req  = own & req_ext[owner_q];
    assign accept     = owner_req & bus.fb_ready;
    assign bcnt_inc   = {1'b0, bcnt_q} + 9'd1;
    assign burst_done = accept & (bcnt_inc == BURST_LIM);

    assign bus.fb_we    = owner_req;
    assign bus.fb_addr  = own ? addr_arr[owner_q] : '0;
    assign bus.fb_wdata = own ? data_arr[owner_q] : '0;
    assign bus.busy     = own;
    assign bus.owner    = owner_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
            assign bus.gnt[gi] = accept & (owner_q == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_OWN;
                    owner_d = pick;
                    bcnt_d  = 8'd0;
                end
            end
            ARB_OWN: begin
                // A dropped request and an accept are mutually exclusive
                // (fb_we follows req), so only one release cause fires.
                if (!req_ext[owner_q] || burst_done) begin
                    state_d = ARB_IDLE;
                    last_d  = owner_q;
                    owner_d = OWNER_NONE;
                    bcnt_d  = 8'd0;
                end else if (accept) begin
                    bcnt_d = bcnt_inc[7:0];
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. last resets to engine 2 so engine 0 wins first.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWNER_NONE;
            last_q  <= REQ_SCORE;
            bcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_spu_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spu_fb_arbiter
// Directed bench for spu_fb_arbiter plus a standalone spu_rr_pick instance.
// ---------------------------------------------------------------------------
module tb_spu_fb_arbiter;
    import spu_pkg::*;

    localparam int AW = SPU_ADDR_W;
    localparam int DW = SPU_DATA_W;

    logic clk;
    logic rst;

    spu_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spu_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] pk_req;
    logic [1:0] pk_last;
    logic       pk_valid;
    logic [1:0] pk_pick;

    spu_rr_pick u_pick (
        .req   (pk_req),
        .last  (pk_last),
        .valid (pk_valid),
        .pick  (pk_pick)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Streaming engine model state
    logic [2:0]    stream_en;
    logic [2:0]    last_gnt;
    int            rem    [3];
    logic [AW-1:0] e_addr [3];
    logic [DW-1:0] e_data [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Engines advance addr/data on the cycle after a gnt and drop req when
    // their stream is exhausted.
    task automatic engine_update();
        logic [2:0]      r;
        logic [3*AW-1:0] a;
        logic [3*DW-1:0] d;
        if (stream_en == 3'b000) return;
        for (int i = 0; i < 3; i++) begin
            if (stream_en[i] && last_gnt[i]) begin
                rem[i]    = rem[i] - 1;
                e_addr[i] = e_addr[i] + 1'b1;
                e_data[i] = e_data[i] + 1'b1;
            end
            r[i]              = stream_en[i] && (rem[i] > 0);
            a[i*AW +: AW]     = e_addr[i];
            d[i*DW +: DW]     = e_data[i];
        end
        bus.req      = r;
        bus.req_addr = a;
        bus.req_data = d;
    endtask

    // Advance one clock; returns at the following negedge.
    task automatic tick();
        last_gnt = bus.gnt;
        @(posedge clk);
        #1;
        engine_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        stream_en    = 3'b000;
        last_gnt     = 3'b000;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.fb_ready = 1'b1;
        e_addr[0] = 17'h00100; e_data[0] = 8'h10;
        e_addr[1] = 17'h01000; e_data[1] = 8'h20;
        e_addr[2] = 17'h10000; e_data[2] = 8'h30;
        for (int i = 0; i < 3; i++) rem[i] = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(bus.busy),  32'd0);
        check({tag, "_owner"}, 32'(bus.owner), 32'(OWNER_NONE));
        check({tag, "_gnt"},   32'(bus.gnt),   32'd0);
        check({tag, "_we"},    32'(bus.fb_we), 32'd0);
    endtask

    initial begin
        logic [2:0] eg;
        logic [1:0] eo;
        logic       ev;
        int         sent;
        int         idx;

        rst = 1'b1;
        pk_req = '0;
        pk_last = '0;

        // ---------------- Test 1: reset state and single write -----------
        do_reset();
        $display("-- t1: reset state, single write from engine 0");
        check_idle("t1_rst");
        check("t1_rst_addr", 32'(bus.fb_addr), 32'd0);
        bus.req          = 3'b001;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.req_addr[AW-1:0] = 17'h00010;
        bus.req_data[DW-1:0] = 8'hA5;
        #1;
        check_idle("t1_arb");
        tick();
        check("t1_owner", 32'(bus.owner),    32'd0);
        check("t1_we",    32'(bus.fb_we),    32'd1);
        check("t1_addr",  32'(bus.fb_addr),  32'h10);
        check("t1_data",  32'(bus.fb_wdata), 32'hA5);
        check("t1_gnt",   32'(bus.gnt),      32'b001);
        check("t1_busy",  32'(bus.busy),     32'd1);
        tick();
        bus.req = 3'b000;
        #1;
        check("t1_hold_busy", 32'(bus.busy),  32'd1);
        check("t1_hold_we",   32'(bus.fb_we), 32'd0);
        check("t1_hold_gnt",  32'(bus.gnt),   32'd0);
        tick();
        check_idle("t1_rel");
        // last is now 0, so engine 1 must win over engine 0
        bus.req = 3'b011;
        #1;
        check_idle("t1_arb2");
        tick();
        check("t1_last_owner", 32'(bus.owner), 32'd1);
        check("t1_last_gnt",   32'(bus.gnt),   32'b010);

        // ---------------- Test 2: all three requesting ---------------------
        do_reset();
        $display("-- t2: req=111 held, round-robin bursts of 16");
        stream_en = 3'b111;
        for (int i = 0; i < 3; i++) rem[i] = 1000;
        engine_update();
        #1;
        check_idle("t2_arb0");
        for (int b = 0; b < 4; b++) begin
            eg = 3'b001 << (b % 3);
            for (int k = 0; k < 16; k++) begin
                tick();
                check($sformatf("t2_b%0d_k%0d_gnt", b, k), 32'(bus.gnt), 32'(eg));
                if (k == 0)
                    check($sformatf("t2_b%0d_owner", b), 32'(bus.owner), 32'(b % 3));
            end
            tick();
            check($sformatf("t2_b%0d_gap_busy", b), 32'(bus.busy), 32'd0);
            check($sformatf("t2_b%0d_gap_gnt", b),  32'(bus.gnt),  32'd0);
        end

        // ---------------- Test 3: backpressure mid-burst -------------------
        do_reset();
        $display("-- t3: engine 1 stream, fb_ready low for 5 cycles");
        stream_en = 3'b010;
        rem[1] = 100;
        engine_update();
        #1;
        check_idle("t3_arb");
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_pre_k%0d_gnt", k), 32'(bus.gnt), 32'b010);
            tick();
        end
        bus.fb_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("t3_stall%0d_we", s),   32'(bus.fb_we),   32'd1);
            check($sformatf("t3_stall%0d_gnt", s),  32'(bus.gnt),     32'd0);
            check($sformatf("t3_stall%0d_addr", s), 32'(bus.fb_addr), 32'h01005);
            tick();
        end
        bus.fb_ready = 1'b1;
        #1;
        for (int k = 0; k < 11; k++) begin
            check($sformatf("t3_post_k%0d_gnt", k),  32'(bus.gnt),     32'b010);
            check($sformatf("t3_post_k%0d_addr", k), 32'(bus.fb_addr), 32'h01005 + 32'(k));
            tick();
        end
        check_idle("t3_rel");

        // ---------------- Test 4: sole requester, 40 writes ----------------
        do_reset();
        $display("-- t4: engine 2 sole requester, 40-write stream");
        stream_en = 3'b100;
        rem[2] = 40;
        engine_update();
        #1;
        check_idle("t4_arb");
        tick();
        sent = 0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < ((b == 2) ? 8 : 16); k++) begin
                check($sformatf("t4_b%0d_k%0d_gnt", b, k), 32'(bus.gnt), 32'b100);
                check($sformatf("t4_b%0d_k%0d_addr", b, k), 32'(bus.fb_addr), 32'h10000 + 32'(sent));
                sent++;
                tick();
            end
            if (b < 2) begin
                check_idle($sformatf("t4_gap%0d", b));
                tick();
            end
        end
        check("t4_end_busy", 32'(bus.busy),  32'd1);
        check("t4_end_we",   32'(bus.fb_we), 32'd0);
        check("t4_end_gnt",  32'(bus.gnt),   32'd0);
        tick();
        check_idle("t4_rel");

        // ---------------- Test 5: reset mid-burst --------------------------
        do_reset();
        $display("-- t5: reset during 7th write of engine 0 burst");
        stream_en = 3'b001;
        rem[0] = 100;
        engine_update();
        #1;
        tick();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t5_k%0d_gnt", k), 32'(bus.gnt), 32'b001);
            tick();
        end
        check("t5_pre_we", 32'(bus.fb_we), 32'd1);
        rst = 1'b1;
        #1;
        check_idle("t5_async");
        stream_en = 3'b000;
        bus.req   = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 3'b011;
        #1;
        check_idle("t5_arb");
        tick();
        check("t5_owner", 32'(bus.owner), 32'd0);
        check("t5_gnt",   32'(bus.gnt),   32'b001);

        // ---------------- Test 6: picker exhaustive ------------------------
        $display("-- t6: spu_rr_pick exhaustive");
        for (int r = 0; r < 8; r++) begin
            for (int l = 0; l < 3; l++) begin
                pk_req  = 3'(r);
                pk_last = 2'(l);
                ev = (r != 0);
                eo = OWNER_NONE;
                for (int j = 3; j >= 1; j--) begin
                    idx = (l + j) % 3;
                    if (r[idx]) eo = 2'(idx);
                end
                #1;
                check($sformatf("t6_r%0d_l%0d", r, l), 32'({pk_valid, pk_pick}), 32'({ev, eo}));
            end
        end
        pk_req = 3'b101; pk_last = 2'd0;
        #1;
        check("t6_ex_101_l0", 32'(pk_pick), 32'd2);
        pk_req = 3'b000;
        #1;
        check("t6_ex_none", 32'(pk_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
